inc_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one hold-to-step counter among several button-style requesters. Each requester holds its request line; the block grants the shared counter to one requester at a time and runs a hold-delay timer. If the request is still held when the timer expires, the block steps the shared count up or down, with wrap-around at a configurable maximum. It sits between the debounced board inputs and the display/count consumers.

---
 rtl/inc_arbiter_if.sv | 27 ++
 rtl/inc_arbiter.sv | 136 +++++++++++++
 tb/tb_inc_arbiter.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/inc_arbiter_if.sv
// Bus bundle for inc_arbiter: requester inputs, shared settings, and count/grant outputs.
// The master side drives requests and settings; the slave side is the arbiter.
interface inc_arbiter_if #(
  parameter int NREQ = 4,
  parameter int CW   = 16,
  parameter int DW   = 32,
  parameter int IW   = $clog2(NREQ)
);
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] dec;
  logic [DW-1:0]   delay_set;
  logic [CW-1:0]   max_count;
  logic [CW-1:0]   count;
  logic [NREQ-1:0] grant;
  logic            stepped;
  logic [IW-1:0]   stepped_id;

  modport master (
    output req, dec, delay_set, max_count,
    input  count, grant, stepped, stepped_id
  );

  modport slave (
    input  req, dec, delay_set, max_count,
    output count, grant, stepped, stepped_id
  );
endinterface

// File: rtl/inc_arbiter.sv
// Round-robin owner of one hold-to-step counter shared by NREQ button requesters.
// The owner must hold its request for delay_set+1 timer cycles to earn one wrap-around step.
//
// state  | meaning
// S_IDLE | no owner; arbitrate from (last+1) mod NREQ upward
// S_WAIT | owner holds the timer; abort on release, step on expiry
module inc_arbiter #(
  parameter int NREQ = 4,
  parameter int CW   = 16,
  parameter int DW   = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  inc_arbiter_if.slave bus
);
  localparam int IW = $clog2(NREQ);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_count;
  logic [NREQ-1:0] r_grant;
  logic            r_stepped;
  logic [IW-1:0]   r_stepped_id;
  logic [DW-1:0]   r_delay;
  logic [IW-1:0]   r_last;
  logic [IW-1:0]   r_owner;

  state_t          w_state_nxt;
  logic [CW-1:0]   w_count_nxt;
  logic [NREQ-1:0] w_grant_nxt;
  logic            w_stepped_nxt;
  logic [IW-1:0]   w_stepped_id_nxt;
  logic [DW-1:0]   w_delay_nxt;
  logic [IW-1:0]   w_last_nxt;
  logic [IW-1:0]   w_owner_nxt;

  logic            w_win_found;
  logic [IW-1:0]   w_win_idx;
  logic [CW-1:0]   w_step_val;

  // Rotating priority: the requester after the last stepper is searched first.
  always_comb begin
    int idx;
    w_win_found = 1'b0;
    w_win_idx   = '0;
    idx         = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(r_last) + k) % NREQ;
      if (!w_win_found && bus.req[idx]) begin
        w_win_found = 1'b1;
        w_win_idx   = IW'(idx);
      end
    end
  end

  always_comb begin
    w_step_val = r_count;
    if (!bus.dec[r_owner]) begin
      w_step_val = (r_count >= bus.max_count) ? '0 : r_count + CW'(1);
    end else if (r_count == '0 || r_count > bus.max_count) begin
      w_step_val = bus.max_count;
    end else begin
      w_step_val = r_count - CW'(1);
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_count_nxt      = r_count;
    w_grant_nxt      = r_grant;
    w_stepped_nxt    = 1'b0;
    w_stepped_id_nxt = r_stepped_id;
    w_delay_nxt      = r_delay;
    w_last_nxt       = r_last;
    w_owner_nxt      = r_owner;
    case (r_state)
      S_IDLE: begin
        w_grant_nxt = '0;
        if (w_win_found) begin
          w_state_nxt = S_WAIT;
          w_grant_nxt = NREQ'(1) << w_win_idx;
          w_owner_nxt = w_win_idx;
          w_delay_nxt = '0;
        end
      end
      S_WAIT: begin
        if (!bus.req[r_owner]) begin
          w_grant_nxt = '0;
          w_state_nxt = S_IDLE;
        end else if (r_delay < bus.delay_set) begin
          w_delay_nxt = r_delay + DW'(1);
        end else begin
          w_count_nxt      = w_step_val;
          w_stepped_nxt    = 1'b1;
          w_stepped_id_nxt = r_owner;
          w_last_nxt       = r_owner;
          w_grant_nxt      = '0;
          w_delay_nxt      = '0;
          w_state_nxt      = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_count      <= '0;
      r_grant      <= '0;
      r_stepped    <= 1'b0;
      r_stepped_id <= '0;
      r_delay      <= '0;
      r_last       <= IW'(NREQ - 1);
      r_owner      <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_count      <= w_count_nxt;
      r_grant      <= w_grant_nxt;
      r_stepped    <= w_stepped_nxt;
      r_stepped_id <= w_stepped_id_nxt;
      r_delay      <= w_delay_nxt;
      r_last       <= w_last_nxt;
      r_owner      <= w_owner_nxt;
    end
  end

  assign bus.count      = r_count;
  assign bus.grant      = r_grant;
  assign bus.stepped    = r_stepped;
  assign bus.stepped_id = r_stepped_id;
endmodule

// File: tb/tb_inc_arbiter.sv
// Self-checking bench for inc_arbiter: step vectors in a table, multi-cycle corners by hand,
// every expected step queued up front and matched when the step pulse appears.
module tb_inc_arbiter;
  localparam int NREQ = 4;
  localparam int CW   = 16;
  localparam int DW   = 32;

  logic clk;
  logic rst_n;

  inc_arbiter_if #(.NREQ(NREQ), .CW(CW), .DW(DW)) bus ();

  inc_arbiter #(.NREQ(NREQ), .CW(CW), .DW(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int   id;
    logic dec;
    int   dset;
    int   maxc;
    int   exp_count;
  } vec_t;

  typedef struct {
    int count;
    int id;
  } exp_t;

  exp_t sb[$];
  exp_t e_mon;
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (rst_n && bus.stepped) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_step: got count=%0d id=%0d expected no step", bus.count, bus.stepped_id);
      end else begin
        e_mon = sb.pop_front();
        check("step_count", 64'(bus.count), 64'(e_mon.count));
        check("step_id", 64'(bus.stepped_id), 64'(e_mon.id));
      end
    end
  end

  task automatic push_exp(input int count, input int id);
    exp_t e;
    e.count = count;
    e.id    = id;
    sb.push_back(e);
  endtask

  task automatic wait_step(input int limit, output int cycles, output bit ok);
    cycles = 0;
    ok     = 1'b0;
    while (cycles < limit && !ok) begin
      @(posedge clk);
      #1;
      cycles++;
      if (bus.stepped) ok = 1'b1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  vec_t vecs[14];

  initial begin
    int  cyc_n;
    bit  ok;
    int  steps;
    int  prev;

    vecs[0]  = '{1, 1'b1, 2, 9, 9};
    vecs[1]  = '{1, 1'b1, 1, 9, 8};
    vecs[2]  = '{1, 1'b1, 0, 9, 7};
    vecs[3]  = '{3, 1'b0, 1, 3, 0};
    vecs[4]  = '{2, 1'b1, 0, 9, 9};
    vecs[5]  = '{2, 1'b1, 4, 9, 8};
    vecs[6]  = '{0, 1'b1, 0, 9, 7};
    vecs[7]  = '{3, 1'b1, 2, 3, 3};
    vecs[8]  = '{0, 1'b0, 1, 0, 0};
    vecs[9]  = '{1, 1'b1, 0, 0, 0};
    vecs[10] = '{2, 1'b0, 3, 15, 1};
    vecs[11] = '{0, 1'b1, 0, 15, 0};
    vecs[12] = '{1, 1'b1, 1, 15, 15};
    vecs[13] = '{2, 1'b0, 0, 15, 0};

    rst_n         = 1'b0;
    bus.req       = '0;
    bus.dec       = '0;
    bus.delay_set = '0;
    bus.max_count = '0;
    #12;
    check("rst_count", 64'(bus.count), 0);
    check("rst_grant", 64'(bus.grant), 0);
    check("rst_stepped", 64'(bus.stepped), 0);
    check("rst_stepped_id", 64'(bus.stepped_id), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Single requester held: steps every delay_set+2 cycles, wrapping at 5.
    @(posedge clk);
    #1;
    for (int i = 1; i <= 5; i++) push_exp(i, 0);
    push_exp(0, 0);
    bus.max_count = 5;
    bus.delay_set = 3;
    bus.dec       = '0;
    bus.req       = 4'b0001;
    steps = 0;
    prev  = 0;
    for (int cyc = 1; cyc <= 40 && steps < 6; cyc++) begin
      @(posedge clk);
      #1;
      if (cyc == 1) check("held_grant", 64'(bus.grant), 64'(4'b0001));
      if (bus.stepped) begin
        if (steps == 0) check("held_first_latency", 64'(cyc), 5);
        else            check("held_period", 64'(cyc - prev), 5);
        prev = cyc;
        steps++;
      end
    end
    bus.req = '0;
    check("held_steps", 64'(steps), 6);

    for (int v = 0; v < 14; v++) begin
      @(posedge clk);
      #1;
      push_exp(vecs[v].exp_count, vecs[v].id);
      bus.max_count = CW'(vecs[v].maxc);
      bus.delay_set = DW'(vecs[v].dset);
      bus.dec       = NREQ'(vecs[v].dec) << vecs[v].id;
      bus.req       = NREQ'(1) << vecs[v].id;
      wait_step(vecs[v].dset + 10, cyc_n, ok);
      check("vec_step_seen", 64'(ok), 1);
      check("vec_latency", 64'(cyc_n), 64'(vecs[v].dset + 2));
      bus.req = '0;
    end

    // Two requesters with zero delay alternate owners every step.
    @(posedge clk);
    #1;
    push_exp(1, 0);
    push_exp(2, 2);
    push_exp(3, 0);
    push_exp(4, 2);
    bus.max_count = 15;
    bus.delay_set = 0;
    bus.dec       = '0;
    bus.req       = 4'b0101;
    steps = 0;
    prev  = 0;
    for (int cyc = 1; cyc <= 20 && steps < 4; cyc++) begin
      @(posedge clk);
      #1;
      if (cyc % 2 == 1)
        check("rr_grant", 64'(bus.grant), (((cyc - 1) / 2) % 2 == 0) ? 64'(4'b0001) : 64'(4'b0100));
      if (bus.stepped) begin
        check("rr_gap", 64'(cyc - prev), 2);
        prev = cyc;
        steps++;
      end
    end
    bus.req = '0;
    check("rr_steps", 64'(steps), 4);

    // Asynchronous reset in the middle of a long wait.
    @(posedge clk);
    #1;
    check("pre_reset_count", 64'(bus.count), 4);
    bus.delay_set = 10;
    bus.req       = 4'b0010;
    repeat (3) @(posedge clk);
    #2;
    check("mid_wait_grant", 64'(bus.grant), 64'(4'b0010));
    rst_n = 1'b0;
    #1;
    check("async_rst_count", 64'(bus.count), 0);
    check("async_rst_grant", 64'(bus.grant), 0);
    check("async_rst_stepped", 64'(bus.stepped), 0);
    @(posedge clk);
    #1;
    rst_n         = 1'b1;
    push_exp(1, 0);
    bus.req       = 4'b1111;
    bus.dec       = '0;
    bus.delay_set = 2;
    bus.max_count = 15;
    @(posedge clk);
    #1;
    check("post_reset_grant", 64'(bus.grant), 64'(4'b0001));
    wait_step(10, cyc_n, ok);
    check("post_reset_step_seen", 64'(ok), 1);
    check("post_reset_latency", 64'(cyc_n), 3);
    bus.req = '0;

    // Request released at delay=2 aborts with no step; a retry restarts the timer.
    @(posedge clk);
    #1;
    bus.delay_set = 5;
    bus.req       = 4'b0001;
    @(posedge clk);
    #1;
    check("abort_grant_on", 64'(bus.grant), 64'(4'b0001));
    repeat (2) @(posedge clk);
    #1 bus.req = '0;
    @(posedge clk);
    #1;
    check("abort_grant_off", 64'(bus.grant), 0);
    check("abort_no_step", 64'(bus.stepped), 0);
    check("abort_count", 64'(bus.count), 1);
    push_exp(2, 0);
    bus.req = 4'b0001;
    wait_step(20, cyc_n, ok);
    check("retry_step_seen", 64'(ok), 1);
    check("retry_latency", 64'(cyc_n), 7);
    bus.req = '0;

    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", 64'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
